// File: rtl/joypad_port.sv
// rtl/joypad_port.sv - two-port serial joypad interface behind the $4016/$4017 registers.
// A latched OUT0 strobe continuously reloads both pad shift registers; each completed read shifts its own port once.

module joypad_port #(
    parameter logic FILL_BIT = 1'b1
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       addr4016w,
    input  logic [7:0] wdata,
    input  logic       naddr4016r,
    input  logic       naddr4017r,
    input  logic [7:0] buttons1,
    input  logic [7:0] buttons2,
    output logic [7:0] rdata,
    output logic       rdata_oe,
    output logic       strobe
);

    logic [7:0] sr1;
    logic [7:0] sr2;
    logic       prev1;
    logic       prev2;
    logic       read_end1;
    logic       read_end2;
    logic       unused_wdata;

    // Only OUT0 is implemented; the remaining write bits are ignored.
    assign unused_wdata = ^wdata[7:1];

    // A read completes when the strobe line returns high, so long reads still shift once.
    assign read_end1 = !prev1 && naddr4016r;
    assign read_end2 = !prev2 && naddr4017r;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            strobe <= 1'b0;
            prev1  <= 1'b1;
            prev2  <= 1'b1;
        end else begin
            prev1 <= naddr4016r;
            prev2 <= naddr4017r;
            if (addr4016w) begin
                strobe <= wdata[0];
            end
        end
    end

    // The reload/shift choice uses the strobe value held before this edge.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            sr1 <= 8'hFF;
            sr2 <= 8'hFF;
        end else begin
            if (strobe) begin
                sr1 <= buttons1;
            end else if (read_end1) begin
                sr1 <= {FILL_BIT, sr1[7:1]};
            end

            if (strobe) begin
                sr2 <= buttons2;
            end else if (read_end2) begin
                sr2 <= {FILL_BIT, sr2[7:1]};
            end
        end
    end

    // Port 1 wins when both strobes are low together.
    always_comb begin
        rdata = 8'h00;
        if (!naddr4016r) begin
            rdata[0] = strobe ? buttons1[0] : sr1[0];
        end else if (!naddr4017r) begin
            rdata[0] = strobe ? buttons2[0] : sr2[0];
        end
    end

    assign rdata_oe = !naddr4016r || !naddr4017r;

endmodule

// File: tb/tb_joypad_port.sv
// tb/tb_joypad_port.sv - directed self-checking bench for joypad_port.

module tb_joypad_port;

    logic       clock;
    logic       nreset;
    logic       addr4016w;
    logic [7:0] wdata;
    logic       naddr4016r;
    logic       naddr4017r;
    logic [7:0] buttons1;
    logic [7:0] buttons2;
    logic [7:0] rdata;
    logic       rdata_oe;
    logic       strobe;

    int checks;
    int errors;

    joypad_port #(.FILL_BIT(1'b1)) dut (
        .clock      (clock),
        .nreset     (nreset),
        .addr4016w  (addr4016w),
        .wdata      (wdata),
        .naddr4016r (naddr4016r),
        .naddr4017r (naddr4017r),
        .buttons1   (buttons1),
        .buttons2   (buttons2),
        .rdata      (rdata),
        .rdata_oe   (rdata_oe),
        .strobe     (strobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic write4016(input logic [7:0] v);
        @(negedge clock);
        addr4016w = 1'b1;
        wdata     = v;
        @(negedge clock);
        addr4016w = 1'b0;
        wdata     = 8'h00;
    endtask

    // port: 1 = $4016, 2 = $4017, 3 = both; strobe held low for cyc clock edges.
    task automatic rd(input int port, input int cyc, output logic b, output logic oe,
                      output logic [7:0] full);
        @(negedge clock);
        if (port == 1 || port == 3) naddr4016r = 1'b0;
        if (port == 2 || port == 3) naddr4017r = 1'b0;
        #1;
        b    = rdata[0];
        oe   = rdata_oe;
        full = rdata;
        repeat (cyc) @(negedge clock);
        naddr4016r = 1'b1;
        naddr4017r = 1'b1;
    endtask

    task automatic test_reset;
        logic b, oe;
        logic [7:0] f;
        nreset = 1'b0;
        #3;
        checks++;
        if (strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobe got %b want 0", strobe);
        end
        checks++;
        if (rdata !== 8'h00 || rdata_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rdata=%h oe=%b want 00/0", rdata, rdata_oe);
        end
        @(negedge clock);
        nreset = 1'b1;
        rd(1, 1, b, oe, f);
        checks++;
        if (b !== 1'b1 || oe !== 1'b1 || f[7:1] !== 7'd0) begin
            errors++;
            $display("FAIL reset_first_read got b=%b oe=%b rdata=%h want 1/1/01", b, oe, f);
        end
    endtask

    task automatic test_serial_read;
        logic b, oe;
        logic [7:0] f;
        logic [9:0] exp;
        exp = 10'b1100001001; // bit i = expected read i
        buttons1 = 8'h09;
        write4016(8'h01);
        write4016(8'h00);
        for (int i = 0; i < 10; i++) begin
            rd(1, 1, b, oe, f);
            checks++;
            if (b !== exp[i]) begin
                errors++;
                $display("FAIL serial_read_%0d got %b want %b", i, b, exp[i]);
            end
        end
    endtask

    task automatic test_strobe_high;
        logic b, oe;
        logic [7:0] f;
        buttons1 = 8'h00;
        write4016(8'h01);
        checks++;
        if (strobe !== 1'b1) begin
            errors++;
            $display("FAIL strobe_latch got %b want 1", strobe);
        end
        for (int i = 0; i < 2; i++) begin
            rd(1, 1, b, oe, f);
            checks++;
            if (b !== 1'b0) begin
                errors++;
                $display("FAIL strobe_high_before_%0d got %b want 0", i, b);
            end
        end
        buttons1 = 8'h01;
        rd(1, 1, b, oe, f);
        checks++;
        if (b !== 1'b1) begin
            errors++;
            $display("FAIL strobe_high_after got %b want 1", b);
        end
        write4016(8'h00);
        rd(1, 1, b, oe, f);
        checks++;
        if (b !== 1'b1) begin
            errors++;
            $display("FAIL strobe_no_shift_bit0 got %b want 1", b);
        end
        rd(1, 1, b, oe, f);
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL strobe_no_shift_bit1 got %b want 0", b);
        end
    endtask

    task automatic test_port2;
        logic b, oe;
        logic [7:0] f;
        buttons1 = 8'h01;
        buttons2 = 8'h80;
        write4016(8'h01);
        write4016(8'h00);
        for (int i = 0; i < 8; i++) begin
            rd(2, 1, b, oe, f);
            checks++;
            if (b !== (i == 7 ? 1'b1 : 1'b0) || oe !== 1'b1) begin
                errors++;
                $display("FAIL port2_read_%0d got b=%b oe=%b want %b/1", i, b, oe, (i == 7));
            end
        end
        rd(1, 1, b, oe, f);
        checks++;
        if (b !== 1'b1) begin
            errors++;
            $display("FAIL port1_untouched got %b want 1", b);
        end
        rd(1, 1, b, oe, f);
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL port1_second got %b want 0", b);
        end
    endtask

    task automatic test_long_read;
        logic b, oe;
        logic [7:0] f;
        buttons1 = 8'h02;
        write4016(8'h01);
        write4016(8'h00);
        rd(1, 3, b, oe, f);
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL long_read_first got %b want 0", b);
        end
        rd(1, 1, b, oe, f);
        checks++;
        if (b !== 1'b1) begin
            errors++;
            $display("FAIL long_read_second got %b want 1", b);
        end
        rd(1, 1, b, oe, f);
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL long_read_third got %b want 0", b);
        end
    endtask

    task automatic test_both_ports;
        logic b, oe;
        logic [7:0] f;
        buttons1 = 8'h01;
        buttons2 = 8'h02;
        write4016(8'h01);
        write4016(8'h00);
        rd(3, 1, b, oe, f);
        checks++;
        if (b !== 1'b1 || oe !== 1'b1) begin
            errors++;
            $display("FAIL both_priority got b=%b oe=%b want 1/1", b, oe);
        end
        rd(2, 1, b, oe, f);
        checks++;
        if (b !== 1'b1) begin
            errors++;
            $display("FAIL both_port2_shift got %b want 1", b);
        end
        rd(1, 1, b, oe, f);
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL both_port1_shift got %b want 0", b);
        end
    endtask

    task automatic test_reset_mid;
        logic b, oe;
        logic [7:0] f;
        buttons1 = 8'h00;
        write4016(8'h01);
        write4016(8'h00);
        for (int i = 0; i < 3; i++) begin
            rd(1, 1, b, oe, f);
            checks++;
            if (b !== 1'b0) begin
                errors++;
                $display("FAIL mid_pre_read_%0d got %b want 0", i, b);
            end
        end
        @(negedge clock);
        nreset = 1'b0;
        #1;
        checks++;
        if (rdata_oe !== 1'b0 || rdata !== 8'h00 || strobe !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got oe=%b rdata=%h strobe=%b want 0/00/0", rdata_oe, rdata, strobe);
        end
        @(negedge clock);
        nreset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(1, 1, b, oe, f);
            checks++;
            if (b !== 1'b1) begin
                errors++;
                $display("FAIL mid_post_read_%0d got %b want 1", i, b);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic b, oe;
        logic [7:0] f;
        buttons1 = 8'h02;
        write4016(8'h01);
        write4016(8'h00);
        @(negedge clock);
        naddr4016r = 1'b0;
        #1;
        b = rdata[0];
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL coinc_read got %b want 0", b);
        end
        @(negedge clock);
        naddr4016r = 1'b1;
        addr4016w  = 1'b1;
        wdata      = 8'h01;
        @(negedge clock);
        addr4016w = 1'b0;
        wdata     = 8'h00;
        buttons1  = 8'hA5;
        #1;
        checks++;
        if (dut.sr1 !== 8'h81 || strobe !== 1'b1) begin
            errors++;
            $display("FAIL coinc_shift got sr1=%h strobe=%b want 81/1", dut.sr1, strobe);
        end
        @(negedge clock);
        #1;
        checks++;
        if (dut.sr1 !== 8'hA5) begin
            errors++;
            $display("FAIL coinc_reload got sr1=%h want a5", dut.sr1);
        end
        write4016(8'h00);
        rd(1, 1, b, oe, f);
        checks++;
        if (b !== 1'b1) begin
            errors++;
            $display("FAIL coinc_after got %b want 1", b);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        addr4016w  = 1'b0;
        wdata      = 8'h00;
        naddr4016r = 1'b1;
        naddr4017r = 1'b1;
        buttons1   = 8'h00;
        buttons2   = 8'h00;
        test_reset;
        test_serial_read;
        test_strobe_high;
        test_port2;
        test_long_read;
        test_both_ports;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/joypad_port.md
JOYPAD_PORT -- requirements
Module: joypad_port

Interface
REQ-001 Parameter FILL_BIT, default 1'b1, bit shifted into the MSB of each shift register on every shift; once all 8 buttons are read, further reads return it.
REQ-002 clock  input  1  system clock, CPU clock domain; all state updates on rising edge.
REQ-003 nreset  input  1  asynchronous, active-low reset.
REQ-004 addr4016w  input  1  one-cycle write strobe; CPU is writing $4016 this cycle.
REQ-005 wdata  input  8  CPU write data, sampled when addr4016w=1; only bit 0 (OUT0) used.
REQ-006 naddr4016r  input  1  active-low read strobe for $4016 (port 1); may stay low 1 or more cycles.
REQ-007 naddr4017r  input  1  active-low read strobe for $4017 (port 2).
REQ-008 buttons1  input  8  port 1 pad, active-high: bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
REQ-009 buttons2  input  8  port 2 pad, same bit order as buttons1.
REQ-010 rdata  output  8  read data to CPU; bit 0 is the serial bit; bits 7:1 always 0.
REQ-011 rdata_oe  output  1  high while either read strobe is low; CPU muxes rdata onto data_in only when high.
REQ-012 strobe  output  1  registered OUT0 latch value.

Function
REQ-013 strobe SHALL load wdata[0] on each rising edge where addr4016w=1; otherwise it holds.
REQ-014 While strobe=1, sr1<=buttons1 and sr2<=buttons2 SHALL occur every clock edge (continuous reload); no shifting occurs.
REQ-015 On strobe 1->0, each shift register SHALL hold the value loaded on the last edge where strobe was 1.
REQ-016 prev1/prev2 SHALL register naddr4016r/naddr4017r each cycle; a read-end edge is prev=0 and current=1.
REQ-017 On a read-end edge of port N while strobe=0, srN SHALL become {FILL_BIT, srN[7:1]}; exactly one shift per strobe low-period, however long the strobe is held low.
REQ-018 rdata[0] SHALL be combinational: port 1 read (naddr4016r=0) gives strobe ? buttons1[0] : sr1[0]; port 2 read gives strobe ? buttons2[0] : sr2[0]; no read gives 0.
REQ-019 If both read strobes are low together, rdata[0] SHALL come from port 1, and each port shifts independently on its own edge.
REQ-020 Shift-vs-reload decision SHALL use the strobe value held before the edge; a $4016 write coinciding with a read-end edge does not block that shift; the new strobe takes effect the next edge.
REQ-021 A read of one port SHALL never alter the other port's shift register.
REQ-022 Latency: a shift is visible on rdata at the next read, i.e. one cycle after the read-end edge at the earliest.

Reset
REQ-023 While nreset=0, independent of clock: strobe=0, sr1=sr2=8'hFF, prev1=prev2=1; so rdata=8'h00 and rdata_oe=0 with no read active.
REQ-024 Reset mid-sequence SHALL discard the partially read state; reads after release and before any strobe return 1.

Verification
REQ-025 buttons1=8'h09; write $4016 with 1 then 0; 10 port-1 reads -> rdata[0] = 1,0,0,1,0,0,0,0,1,1.
REQ-026 strobe=1, buttons1 goes 8'h00 -> 8'h01 mid-test; three port-1 reads -> 0 before the change, 1 after it, never shifted.
REQ-027 buttons2=8'h80, latch; 8 port-2 reads -> seven 0s then 1; a following port-1 read returns the latched buttons1[0].
REQ-028 naddr4016r held low 3 cycles, buttons1=8'h02 latched -> first read 0, single shift, next read 1.
REQ-029 nreset pulsed low after 3 of 8 reads -> rdata_oe=0 during reset; subsequent reads return 1 until a new latch.
REQ-030 addr4016w with wdata=8'h01 on the same edge as a port-1 read-end edge -> that shift happens; the next edge reloads from buttons1.
